// File: rtl/dec2to4_seq.sv
// dec2to4_seq: sequential 2-to-4 one-hot decoder with valid/ready intake.
// An accepted code drives its one-hot line on Y for HOLD cycles, then Y is
// cleared and done pulses for one cycle. Dropping en aborts a hold silently.
// Optional feature macro: DEC_HITCNT_EN adds saturating per-line accept
// counters on hit_cnt; without it hit_cnt is tied to zero.
module dec2to4_seq #(
  parameter int HOLD = 4,
  parameter int CW   = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [1:0]    code,
  output logic [3:0]    Y,
  output logic          busy,
  output logic          done,
  output logic [4*CW-1:0] hit_cnt
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  // HOLD=0 is illegal; load 0 rather than letting HOLD-1 wrap to 255.
  localparam logic [7:0] HOLD_M1 = (HOLD < 1) ? 8'd0 : 8'(HOLD - 1);

  state_t     state_q;
  logic [7:0] cnt_q;
  logic [3:0] y_q;
  logic       done_q;
  logic [3:0] y_d;
  logic       accept;

  assign in_ready = (state_q == IDLE) & en & ~rst;
  assign accept   = in_valid & in_ready;

  // One-hot image of the presented code, captured only on accept.
  always_comb begin
    y_d = 4'b0001 << code;
  end

  // Decoder FSM: accept, count down the hold, then clear with done or abort.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      y_q     <= 4'b0000;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            y_q     <= y_d;
            cnt_q   <= HOLD_M1;
            state_q <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (!en) begin
            // Abort beats a coincident terminal count: no done pulse.
            y_q     <= 4'b0000;
            cnt_q   <= 8'd0;
            state_q <= IDLE;
          end else if (cnt_q != 8'd0) begin
            cnt_q <= cnt_q - 8'd1;
          end else begin
            y_q     <= 4'b0000;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: begin
          y_q     <= 4'b0000;
          cnt_q   <= 8'd0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign Y    = y_q;
  assign busy = (state_q == ACTIVE);
  assign done = done_q;

`ifdef DEC_HITCNT_EN
  logic [CW-1:0] hit_q [4];

  for (genvar i = 0; i < 4; i++) begin : g_hit
    // Saturating count of accepts that selected line i.
    always_ff @(posedge clk) begin
      if (rst) begin
        hit_q[i] <= '0;
      end else if (accept && (code == 2'(i)) && !(&hit_q[i])) begin
        hit_q[i] <= hit_q[i] + CW'(1);
      end
    end
    assign hit_cnt[i*CW +: CW] = hit_q[i];
  end
`else
  assign hit_cnt = '0;
`endif

  // A zero hold length is a configuration error.
  a_hold_legal: assert property (@(posedge clk) HOLD != 0);

  // Y may only ever carry a single line or nothing.
  a_y_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(y_q));

endmodule

// File: tb/tb_dec2to4_seq.sv
// Directed bench for dec2to4_seq with HOLD=4.
module tb_dec2to4_seq;

`ifdef DEC_HITCNT_EN
  localparam int CW = 2;
`else
  localparam int CW = 8;
`endif
  localparam int HOLD = 4;

  logic          clk = 1'b0;
  logic          rst, en, in_valid, in_ready, busy, done;
  logic [1:0]    code;
  logic [3:0]    Y;
  logic [4*CW-1:0] hit_cnt;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  dec2to4_seq #(.HOLD(HOLD), .CW(CW)) dut (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(in_ready),
    .code(code), .Y(Y), .busy(busy), .done(done), .hit_cnt(hit_cnt)
  );

  always #5 clk = ~clk;

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; in_valid = 1'b0; code = 2'b00;
    tick(); tick();
    checks++; if (Y !== 4'b0000) begin errors++; $display("FAIL reset_Y got %b want 0000", Y); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    en = 1'b1; #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    checks++; if (hit_cnt !== '0) begin errors++; $display("FAIL reset_hit_cnt got %h want 0", hit_cnt); end
    rst = 1'b0; #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL idle_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_single();
    in_valid = 1'b1; code = 2'b10;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < HOLD; k++) begin
      checks++; if (Y !== 4'b0100) begin errors++; $display("FAIL single_Y c%0d got %b want 0100", k, Y); end
      checks++; if (busy !== 1'b1 || done !== 1'b0 || in_ready !== 1'b0) begin
        errors++; $display("FAIL single_flags c%0d got busy=%b done=%b rdy=%b want 1 0 0", k, busy, done, in_ready);
      end
      tick();
    end
    checks++; if (Y !== 4'b0000 || done !== 1'b1) begin errors++; $display("FAIL single_end got Y=%b done=%b want 0000 1", Y, done); end
    checks++; if (busy !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL single_ready got busy=%b rdy=%b want 0 1", busy, in_ready); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL single_done_pulse got %b want 0", done); end
  endtask

  task automatic test_back_to_back();
    int ndone = 0;
    int t_acc [4];
    logic [3:0] exp_y;
    in_valid = 1'b1;
    for (int j = 0; j < 4; j++) begin
      code = 2'(j);
      #1;
      for (int w = 0; w < 10 && !in_ready; w++) tick();
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_timeout code %0d got %b want 1", j, in_ready); end
      tick();
      t_acc[j] = cyc;
      case (j)
        0: exp_y = 4'b0001;
        1: exp_y = 4'b0010;
        2: exp_y = 4'b0100;
        default: exp_y = 4'b1000;
      endcase
      for (int k = 0; k < HOLD; k++) begin
        checks++; if (Y !== exp_y) begin errors++; $display("FAIL b2b_Y code %0d c%0d got %b want %b", j, k, Y, exp_y); end
        tick();
      end
      checks++; if (Y !== 4'b0000) begin errors++; $display("FAIL b2b_gap code %0d got %b want 0000", j, Y); end
      if (done === 1'b1) ndone++;
    end
    in_valid = 1'b0;
    checks++; if (ndone !== 4) begin errors++; $display("FAIL b2b_done_count got %0d want 4", ndone); end
    for (int j = 1; j < 4; j++) begin
      checks++; if (t_acc[j] - t_acc[j-1] !== HOLD + 1) begin
        errors++; $display("FAIL b2b_spacing %0d got %0d want %0d", j, t_acc[j] - t_acc[j-1], HOLD + 1);
      end
    end
    tick();
  endtask

  task automatic test_abort();
    in_valid = 1'b1; code = 2'b11;
    tick();
    in_valid = 1'b0;
    checks++; if (Y !== 4'b1000) begin errors++; $display("FAIL abort_Y1 got %b want 1000", Y); end
    tick();
    en = 1'b0; #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL abort_rdy_active got %b want 0", in_ready); end
    tick();
    checks++; if (Y !== 4'b0000 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL abort_clear got Y=%b busy=%b done=%b want 0000 0 0", Y, busy, done);
    end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL abort_rdy_en_low got %b want 0", in_ready); end
    tick();
    checks++; if (done !== 1'b0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL abort_later got done=%b rdy=%b want 0 0", done, in_ready);
    end
    en = 1'b1; #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL abort_rdy_restored got %b want 1", in_ready); end
  endtask

  task automatic test_rst_mid();
    in_valid = 1'b1; code = 2'b01;
    tick();
    code = 2'b00;
    checks++; if (Y !== 4'b0010) begin errors++; $display("FAIL rstmid_Y1 got %b want 0010", Y); end
    tick(); tick();
    rst = 1'b1;
    tick();
    checks++; if (Y !== 4'b0000 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL rstmid_clear got Y=%b busy=%b done=%b want 0000 0 0", Y, busy, done);
    end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rstmid_rdy got %b want 0", in_ready); end
    tick();
    checks++; if (Y !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_no_accept got Y=%b busy=%b want 0000 0", Y, busy); end
    in_valid = 1'b0;
    rst = 1'b0;
    tick();
    checks++; if (Y !== 4'b0000 || hit_cnt !== '0) begin
      errors++; $display("FAIL rstmid_after got Y=%b hit=%h want 0000 0", Y, hit_cnt);
    end
  endtask

  task automatic test_code_change();
    in_valid = 1'b1; code = 2'b00;
    tick();
    code = 2'b11;
    for (int k = 0; k < HOLD; k++) begin
      checks++; if (Y !== 4'b0001) begin errors++; $display("FAIL chg_Y c%0d got %b want 0001", k, Y); end
      tick();
    end
    checks++; if (Y !== 4'b0000 || done !== 1'b1 || in_ready !== 1'b1) begin
      errors++; $display("FAIL chg_end got Y=%b done=%b rdy=%b want 0000 1 1", Y, done, in_ready);
    end
    tick();
    in_valid = 1'b0;
    checks++; if (Y !== 4'b1000) begin errors++; $display("FAIL chg_second got %b want 1000", Y); end
    repeat (HOLD) tick();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL chg_second_done got %b want 1", done); end
    tick();
  endtask

  task automatic test_hitcnt();
    logic [CW-1:0] exp0;
    rst = 1'b1; tick(); rst = 1'b0;
    for (int n = 0; n < 5; n++) begin
      in_valid = 1'b1; code = 2'b00;
      tick();
      in_valid = 1'b0;
      repeat (HOLD) tick();
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL hit_done %0d got %b want 1", n, done); end
    end
`ifdef DEC_HITCNT_EN
    exp0 = (5 > (1 << CW) - 1) ? CW'((1 << CW) - 1) : CW'(5);
`else
    exp0 = '0;
`endif
    checks++; if (hit_cnt[CW-1:0] !== exp0) begin errors++; $display("FAIL hit_line0 got %0d want %0d", hit_cnt[CW-1:0], exp0); end
    checks++; if (hit_cnt[4*CW-1:CW] !== '0) begin errors++; $display("FAIL hit_others got %h want 0", hit_cnt[4*CW-1:CW]); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_abort();
    test_rst_mid();
    test_code_change();
    test_hitcnt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
